// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes,
// datapath mux selects and fault codes.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11,
    FAULT  = 4'd12
  } stateT;

  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] ADDIU = 6'b001001;
  localparam logic [5:0] J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  // One control word per state; the top gates the strobes during reset.
  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic       instrDone;
    logic       fault;
  } ctrlT;

  function automatic logic isWaitState(input stateT s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts memory wait cycles within one state and flags when the
// last permitted cycle has been reached.
module mc_wait_timer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_countEn,
  output logic o_expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      count <= '0;
    end else if (i_countEn && !o_expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign o_expired = (count == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the shared multicycle MIPS datapath, with memory
// stall handling, access timeout and illegal-opcode trap.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_opcode,
  input  logic       i_memReady,
  output logic       o_pcWrite,
  output logic       o_pcWriteCond,
  output logic       o_iorD,
  output logic       o_memRead,
  output logic       o_memWrite,
  output logic       o_irWrite,
  output logic       o_regDst,
  output logic       o_memToReg,
  output logic       o_regWrite,
  output logic       o_aluSrcA,
  output logic [1:0] o_aluSrcB,
  output logic [1:0] o_aluOp,
  output logic [1:0] o_pcSource,
  output logic       o_instrDone,
  output logic       o_fault,
  output logic [1:0] o_faultCode,
  output logic [3:0] o_state
);

  stateT      state, stateNext;
  logic [1:0] faultCodeQ, faultCodeNext;
  logic       timerExpired;
  ctrlT       ctrl;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, regardless of process evaluation order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= FETCH;
      faultCodeQ <= FAULT_NONE;
    end else begin
      state      <= stateNext;
      faultCodeQ <= faultCodeNext;
    end
  end

  // Any state change restarts the count, so each wait state starts from zero.
  mc_wait_timer #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_waitTimer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (stateNext != state),
    .i_countEn(isWaitState(state) && !i_memReady),
    .o_expired(timerExpired)
  );

  // NOTE: every variable gets a default before the case so no path through
  // this block leaves one unassigned, which would infer a latch.
  always_comb begin
    stateNext     = state;
    faultCodeNext = FAULT_NONE;
    unique case (state)
      FETCH: begin
        if (i_memReady) begin
          stateNext = DECODE;
        end else if (timerExpired) begin
          stateNext     = FAULT;
          faultCodeNext = FAULT_TIMEOUT;
        end
      end
      DECODE: begin
        case (i_opcode)
          RTYPE:        stateNext = EXEC;
          LW, SW:       stateNext = MEMADR;
          BEQ:          stateNext = BRANCH;
          ADDI, ADDIU:  stateNext = ADDIEX;
          J:            stateNext = JUMP;
          default: begin
            stateNext     = FAULT;
            faultCodeNext = FAULT_ILLEGAL;
          end
        endcase
      end
      MEMADR: stateNext = (i_opcode == LW) ? MEMRD : MEMWR;
      MEMRD: begin
        if (i_memReady) begin
          stateNext = MEMWB;
        end else if (timerExpired) begin
          stateNext     = FAULT;
          faultCodeNext = FAULT_TIMEOUT;
        end
      end
      MEMWR: begin
        if (i_memReady) begin
          stateNext = FETCH;
        end else if (timerExpired) begin
          stateNext     = FAULT;
          faultCodeNext = FAULT_TIMEOUT;
        end
      end
      EXEC:    stateNext = RWB;
      ADDIEX:  stateNext = ADDIWB;
      default: stateNext = FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.memRead  = 1'b1;
        ctrl.aluSrcB  = SRCB_FOUR;
        ctrl.aluOp    = ALU_ADD;
        ctrl.pcSource = PCSRC_ALU;
        ctrl.irWrite  = i_memReady;
        ctrl.pcWrite  = i_memReady;
      end
      DECODE: begin
        ctrl.aluSrcB = SRCB_IMMSH;
        ctrl.aluOp   = ALU_ADD;
      end
      MEMADR, ADDIEX: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALU_ADD;
      end
      MEMRD: begin
        ctrl.memRead = 1'b1;
        ctrl.iorD    = 1'b1;
      end
      MEMWB: begin
        ctrl.memToReg  = 1'b1;
        ctrl.regWrite  = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      MEMWR: begin
        ctrl.memWrite  = 1'b1;
        ctrl.iorD      = 1'b1;
        ctrl.instrDone = i_memReady;
      end
      EXEC: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_REG;
        ctrl.aluOp   = ALU_FUNCT;
      end
      RWB: begin
        ctrl.regDst    = 1'b1;
        ctrl.regWrite  = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      BRANCH: begin
        ctrl.aluSrcA     = 1'b1;
        ctrl.aluSrcB     = SRCB_REG;
        ctrl.aluOp       = ALU_SUB;
        ctrl.pcSource    = PCSRC_ALUOUT;
        ctrl.pcWriteCond = 1'b1;
        ctrl.instrDone   = 1'b1;
      end
      ADDIWB: begin
        ctrl.regWrite  = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      JUMP: begin
        ctrl.pcSource  = PCSRC_JUMP;
        ctrl.pcWrite   = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      default: ctrl.fault = 1'b1;  // FAULT and the unused encodings
    endcase
  end

  // Strobes are held low while reset is asserted, even before the first edge.
  assign o_pcWrite     = i_rst_n & ctrl.pcWrite;
  assign o_pcWriteCond = i_rst_n & ctrl.pcWriteCond;
  assign o_memRead     = i_rst_n & ctrl.memRead;
  assign o_memWrite    = i_rst_n & ctrl.memWrite;
  assign o_irWrite     = i_rst_n & ctrl.irWrite;
  assign o_regWrite    = i_rst_n & ctrl.regWrite;
  assign o_instrDone   = i_rst_n & ctrl.instrDone;
  assign o_fault       = i_rst_n & ctrl.fault;

  assign o_iorD        = ctrl.iorD;
  assign o_regDst      = ctrl.regDst;
  assign o_memToReg    = ctrl.memToReg;
  assign o_aluSrcA     = ctrl.aluSrcA;
  assign o_aluSrcB     = ctrl.aluSrcB;
  assign o_aluOp       = ctrl.aluOp;
  assign o_pcSource    = ctrl.pcSource;

  assign o_faultCode = (o_fault && state == FAULT) ? faultCodeQ : FAULT_NONE;
  assign o_state     = state;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style FSM that sequences the shared multicycle MIPS datapath: one memory port, one ALU, and IR/MDR/A/B/ALUOut holding registers.
- Replaces the single-cycle opcode decoder when the core is built in multicycle mode.
- Supported instructions: R-type (add, sub, and, or, addu, subu), beq, lw, sw, addi, addiu, j.
- Stalls on a memory-ready handshake, times out stuck memory accesses, and traps illegal opcodes.

Parameters:
- TIMEOUT, 16, maximum cycles spent waiting for i_memReady in one memory state before a bus fault (must be >= 2).
- CNT_W, 5, width of the wait counter (must satisfy 2^CNT_W > TIMEOUT).

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  synchronous active-low reset
- i_opcode  in  6  IR[31:26]; valid from DECODE onward
- i_memReady  in  1  memory completes the current access this cycle
- o_pcWrite  out  1  unconditional PC load
- o_pcWriteCond  out  1  PC load qualified by ALU zero
- o_iorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- o_memRead  out  1  memory read request
- o_memWrite  out  1  memory write request
- o_irWrite  out  1  IR load
- o_regDst  out  1  destination register select: 1 = rd, 0 = rt
- o_memToReg  out  1  write-back select: 1 = MDR, 0 = ALUOut
- o_regWrite  out  1  register file write
- o_aluSrcA  out  1  ALU A select: 0 = PC, 1 = A
- o_aluSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- o_aluOp  out  2  00 = add, 01 = sub, 10 = use funct
- o_pcSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- o_instrDone  out  1  one-cycle pulse in the final cycle of each instruction
- o_fault  out  1  one-cycle fault pulse
- o_faultCode  out  2  01 = illegal opcode, 10 = memory timeout; 00 when o_fault = 0
- o_state  out  4  current state, for debug

Behaviour:
- Reset: i_rst_n low at a clock edge sets state = FETCH and clears the wait counter.
- While i_rst_n is low, all strobes are forced to 0 combinationally: pcWrite, pcWriteCond, memRead, memWrite, irWrite, regWrite, instrDone, fault.
- After reset, outputs take the FETCH values below.
- Every output not listed for a state is 0.

States, per-state outputs and transitions:
- FETCH (0): memRead = 1, iorD = 0, aluSrcA = 0, aluSrcB = 01, aluOp = 00, pcSource = 00; irWrite = pcWrite = i_memReady. Goes to DECODE when ready, otherwise stays.
- DECODE (1): aluSrcA = 0, aluSrcB = 11, aluOp = 00 (precomputes the branch target). Next state by opcode:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 00100? -> ADDIEX
  - 000010 -> JUMP
  - any other -> FAULT, code 01
- MEMADR (2): aluSrcA = 1, aluSrcB = 10, aluOp = 00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD (3): memRead = 1, iorD = 1. Goes to MEMWB when ready.
- MEMWB (4): regDst = 0, memToReg = 1, regWrite = 1, instrDone = 1. Goes to FETCH.
- MEMWR (5): memWrite = 1, iorD = 1, instrDone = i_memReady. Goes to FETCH when ready.
- EXEC (6): aluSrcA = 1, aluSrcB = 00, aluOp = 10. Goes to RWB.
- RWB (7): regDst = 1, memToReg = 0, regWrite = 1, instrDone = 1. Goes to FETCH.
- BRANCH (8): aluSrcA = 1, aluSrcB = 00, aluOp = 01, pcSource = 01, pcWriteCond = 1, instrDone = 1. Goes to FETCH.
- ADDIEX (9): aluSrcA = 1, aluSrcB = 10, aluOp = 00. Goes to ADDIWB.
- ADDIWB (10): regDst = 0, memToReg = 0, regWrite = 1, instrDone = 1. Goes to FETCH.
- JUMP (11): pcSource = 10, pcWrite = 1, instrDone = 1. Goes to FETCH.
- FAULT (12): fault = 1, faultCode as latched on entry. Goes to FETCH. The PC has already advanced, so the faulting instruction is skipped.
- Unused encodings 13-15: treated as FAULT with code 00, then FETCH.

Wait counter (FETCH, MEMRD, MEMWR):
- Cleared on entry to each of these states.
- Increments each cycle ready is low.
- If count == TIMEOUT-1 and ready is low, next state = FAULT with code 10; no IR, PC or register write occurs.
- If ready coincides with the timeout cycle, ready wins and the normal transition is taken.

Latency, with ready asserted in the first cycle of each memory state:
- lw 5 cycles; sw 4; R-type 4; addi 4; beq 3; j 3.
- Each memory wait cycle adds 1.

Decomposition:
- mc_pkg holds:
  - state encodings
  - opcode constants: RTYPE, LW, SW, BEQ, ADDI, ADDIU, J
  - aluOp, aluSrcB and pcSource encodings
  - fault codes
- Sub-module mc_wait_timer (clear, count enable, expired flag), parameterised by TIMEOUT and CNT_W.

Test Plan:
- Reset held for 2 cycles with i_memReady = 1 -> all strobes 0 during reset; first cycle after release: o_state = 0, o_memRead = 1, o_aluSrcB = 01, o_irWrite = o_pcWrite = 1.
- lw (100011), ready always 1 -> states 0, 1, 2, 3, 4; o_regWrite = 1 and o_memToReg = 1 in cycle 5; o_instrDone pulses once.
- sw (101011), ready held low 3 cycles in MEMWR -> o_memWrite high for 4 cycles; o_instrDone only in the ready cycle; o_regWrite never 1.
- beq (000100), then j (000010) -> BRANCH: o_pcWriteCond = 1, o_pcSource = 01, o_aluOp = 01; JUMP: o_pcWrite = 1, o_pcSource = 10; 3 cycles each.
- Opcode 111111 -> DECODE then FAULT; o_fault = 1 and o_faultCode = 01 for exactly 1 cycle; then FETCH.
- TIMEOUT = 16, ready never asserted in FETCH -> 16 cycles in FETCH, then o_faultCode = 10, no o_irWrite. Repeat with ready in the 16th cycle -> no fault, DECODE follows.
